fifo_to_axi4: RTL and testbench
===============================

Name: fifo_to_axi4

Overview:
- Write-direction companion of the AXI4 read-to-FIFO adapter.
- Drains a show-ahead (first-word-fall-through) write FIFO and issues fixed-length INCR AXI4 write bursts to DDR.
- Addresses run over the circular byte window [WR_AXI_BYTE_ADDR_BEGIN, WR_AXI_BYTE_ADDR_END).
- Sits between the user-side write FIFO and the AXI interconnect / memory-controller slave port.

Parameters:
WR_AXI_BYTE_ADDR_BEGIN, 0, window start byte address (burst-aligned)
AXI_DATA_WIDTH, 64, AXI data width in bits (power of 2, >= 8)
AXI_ADDR_WIDTH, 32, AXI address width
AXI_ID_WIDTH, 4, AXI ID width
AXI_ID, 4'b0000, constant AWID; expected BID
AXI_BURST_LEN, 8'd31, AWLEN; beats per burst = AXI_BURST_LEN+1
FIFO_ADDR_WIDTH, 8, width of fifo_rd_cnt

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
WR_AXI_BYTE_ADDR_END  in  24  window end byte address (exclusive); quasi-static
addr_clr  in  1  request address restart at window begin
fifo_rdreq  out  1  FIFO pop (show-ahead)
fifo_rddata  in  AXI_DATA_WIDTH  FIFO head word
fifo_empty  in  1  FIFO empty
fifo_rd_cnt  in  FIFO_ADDR_WIDTH  FIFO occupancy
fifo_rst_busy  in  1  FIFO in reset; no requests while high
wr_resp_err  out  1  one-cycle pulse on a bad B response
m_axi_awid  out  AXI_ID_WIDTH  = AXI_ID
m_axi_awaddr  out  AXI_ADDR_WIDTH  burst start address
m_axi_awlen  out  8  = AXI_BURST_LEN
m_axi_awsize  out  3  = clog2(AXI_DATA_WIDTH/8)
m_axi_awburst  out  2  = 2'b01
m_axi_awlock/awcache/awprot/awqos/awregion  out  1/4/3/4/4  all zero
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  AXI_DATA_WIDTH  = fifo_rddata
m_axi_wstrb  out  AXI_DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bid  in  AXI_ID_WIDTH  response ID
m_axi_bresp  in  2  response code
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset values (reset_n low, async):
  - state S_IDLE; m_axi_awaddr = WR_AXI_BYTE_ADDR_BEGIN.
  - beat counter 0; clear-pending flag 0.
  - m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, fifo_rdreq and wr_resp_err all 0.
- Start condition: wr_req = !fifo_rst_busy && fifo_rd_cnt >= AXI_BURST_LEN+1. Compare at FIFO_ADDR_WIDTH+1 bits.
- State machine (registered state; one-hot S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP):
  - S_IDLE -> S_WR_ADDR when wr_req. If addr_clr or clear-pending is set, first load BEGIN and drop pending; stay in S_IDLE that cycle.
  - S_WR_ADDR: m_axi_awvalid = 1. awaddr and all AW fields are stable. -> S_WR_DATA on awvalid && awready.
  - S_WR_DATA:
    - m_axi_wvalid = !fifo_empty.
    - fifo_rdreq = m_axi_wvalid && m_axi_wready, combinational.
    - Beat counter increments on each W handshake.
    - m_axi_wlast = (counter == AXI_BURST_LEN) && wvalid.
    - On the wlast handshake: counter <= 0 and -> S_WR_RESP.
    - W never starts before the AW handshake; no write interleaving; one outstanding burst.
  - S_WR_RESP: m_axi_bready = 1. On bvalid -> S_IDLE, and:
    - Address update: next = awaddr + (AXI_BURST_LEN+1)*(AXI_DATA_WIDTH/8). If next >= WR_AXI_BYTE_ADDR_END, or addr_clr / clear-pending is set, awaddr <= BEGIN and pending clears; else awaddr <= next.
    - The address advances regardless of bresp, because the data is already consumed.
    - wr_resp_err pulses one cycle later when bresp != 2'b00 or bid != AXI_ID.
- addr_clr outside S_IDLE: sets clear-pending. The in-flight burst completes normally (AW, all W beats, B are never truncated). The restart applies at the B handshake.
- FIFO underrun mid-burst: wvalid drops and the counter holds until !fifo_empty. This should not happen, given the start condition.
- wready low: wdata, wlast and wvalid stay stable and no pop occurs.
- Address arithmetic is done at AXI_ADDR_WIDTH bits; END is zero-extended.
- Latency: awvalid is asserted on the first cycle after the S_IDLE cycle in which wr_req is seen. With a 1-cycle awready and continuous wready, the burst takes 1 + (LEN+1) + B-wait cycles.

Test Plan:
1. Defaults, END=24'h1000, FIFO preloaded to 32 words 0..31, awready/wready/bvalid always 1 -> one burst: awaddr 0x0, awlen 31, awsize 3, 32 beats of data 0..31, wlast on beat 31 only, next awaddr 0x100.
2. Continuous supply for 16 bursts with END=24'h1000 -> awaddr sequence 0x000, 0x100 … 0xF00, then 0x000; no awaddr >= 0x1000 is ever issued.
3. fifo_rd_cnt=31 held -> no awvalid. Raise to 32 -> awvalid within 2 cycles. fifo_rst_busy=1 with count 40 -> no request.
4. Random wready (50%) and awready delayed 5 cycles -> wdata stable while wvalid && !wready; exactly 32 pops; awvalid held for 5 cycles.
5. addr_clr pulsed at beat 10 of the burst at 0x300 -> burst completes all 32 beats; next awaddr 0x000, not 0x400.
6. bresp=2'b10 on a burst -> wr_resp_err one-cycle pulse, address still advances by 0x100. Then reset_n asserted mid-S_WR_DATA -> all outputs 0 immediately and awaddr = BEGIN.

Source files
------------

// File: rtl/fifo_to_axi4.sv
// Drains a show-ahead FIFO into fixed-length INCR AXI4 write bursts over a circular address window.
// AW one cycle after a full burst is available; W stalls on wready or FIFO empty; one outstanding burst.
module fifo_to_axi4 #(
   parameter int                        AXI_DATA_WIDTH         = 64,
   parameter int                        AXI_ADDR_WIDTH         = 32,
   parameter int                        AXI_ID_WIDTH           = 4,
   parameter logic [AXI_ADDR_WIDTH-1:0] WR_AXI_BYTE_ADDR_BEGIN = '0,
   parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID                 = '0,
   parameter logic [7:0]                AXI_BURST_LEN          = 8'd31,
   parameter int                        FIFO_ADDR_WIDTH        = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [23:0]                   WR_AXI_BYTE_ADDR_END,
   input  logic                          addr_clr,
   output logic                          fifo_rdreq,
   input  logic [AXI_DATA_WIDTH-1:0]     fifo_rddata,
   input  logic                          fifo_empty,
   input  logic [FIFO_ADDR_WIDTH-1:0]    fifo_rd_cnt,
   input  logic                          fifo_rst_busy,
   output logic                          wr_resp_err,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic                          m_axi_awlock,
   output logic [3:0]                    m_axi_awcache,
   output logic [2:0]                    m_axi_awprot,
   output logic [3:0]                    m_axi_awqos,
   output logic [3:0]                    m_axi_awregion,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready
);

   localparam int SIZE = $clog2(AXI_DATA_WIDTH/8);
   localparam logic [FIFO_ADDR_WIDTH:0] BEATS = (FIFO_ADDR_WIDTH+1)'(AXI_BURST_LEN) + 1'b1;
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_INC =
      AXI_ADDR_WIDTH'((int'(AXI_BURST_LEN) + 1) * (AXI_DATA_WIDTH/8));

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_WR_ADDR = 4'b0010,
      S_WR_DATA = 4'b0100,
      S_WR_RESP = 4'b1000
   } state_t;

   state_t                    state, state_nxt;
   logic [7:0]                beat_cnt;
   logic                      clr_pend;
   logic                      wr_req, w_hs, b_hs, restart;
   logic [AXI_ADDR_WIDTH-1:0] end_ext, next_addr;

   assign wr_req    = !fifo_rst_busy && ({1'b0, fifo_rd_cnt} >= BEATS);
   assign w_hs      = m_axi_wvalid && m_axi_wready;
   assign b_hs      = (state == S_WR_RESP) && m_axi_bvalid;
   assign restart   = addr_clr || clr_pend;
   assign end_ext   = {{(AXI_ADDR_WIDTH-24){1'b0}}, WR_AXI_BYTE_ADDR_END};
   assign next_addr = m_axi_awaddr + BURST_INC;

   assign m_axi_awid     = AXI_ID;
   assign m_axi_awlen    = AXI_BURST_LEN;
   assign m_axi_awsize   = 3'(SIZE);
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'b0000;
   assign m_axi_awprot   = 3'b000;
   assign m_axi_awqos    = 4'b0000;
   assign m_axi_awregion = 4'b0000;
   assign m_axi_wdata    = fifo_rddata;
   assign m_axi_wstrb    = '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (!restart && wr_req) state_nxt = S_WR_ADDR;
         S_WR_ADDR: if (m_axi_awready) state_nxt = S_WR_DATA;
         S_WR_DATA: if (w_hs && m_axi_wlast) state_nxt = S_WR_RESP;
         S_WR_RESP: if (m_axi_bvalid) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      fifo_rdreq    = 1'b0;
      case (state)
         S_WR_ADDR: m_axi_awvalid = 1'b1;
         S_WR_DATA: begin
            m_axi_wvalid = !fifo_empty;
            m_axi_wlast  = (beat_cnt == AXI_BURST_LEN) && !fifo_empty;
            fifo_rdreq   = !fifo_empty && m_axi_wready;
         end
         S_WR_RESP: m_axi_bready = 1'b1;
         default: ;
      endcase
   end

   // The address moves on even after an error response: the data has already left the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axi_awaddr <= WR_AXI_BYTE_ADDR_BEGIN;
         beat_cnt     <= 8'd0;
         clr_pend     <= 1'b0;
         wr_resp_err  <= 1'b0;
      end else begin
         wr_resp_err <= b_hs && ((m_axi_bresp != 2'b00) || (m_axi_bid != AXI_ID));
         if (state == S_IDLE) begin
            if (restart) begin
               m_axi_awaddr <= WR_AXI_BYTE_ADDR_BEGIN;
               clr_pend     <= 1'b0;
            end
         end else if (b_hs) begin
            if ((next_addr >= end_ext) || restart) m_axi_awaddr <= WR_AXI_BYTE_ADDR_BEGIN;
            else                                   m_axi_awaddr <= next_addr;
            clr_pend <= 1'b0;
         end else if (addr_clr) begin
            clr_pend <= 1'b1;
         end
         if (w_hs && m_axi_wlast) beat_cnt <= 8'd0;
         else if (w_hs)           beat_cnt <= beat_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_fifo_to_axi4.sv
// Bench for fifo_to_axi4: behavioural show-ahead FIFO, data scoreboard and a table of burst vectors.
module tb_fifo_to_axi4;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] end_addr;
   logic        addr_clr, fifo_rdreq, fifo_empty, fifo_rst_busy, wr_resp_err;
   logic [63:0] fifo_rddata;
   logic [7:0]  fifo_rd_cnt;
   logic [3:0]  m_axi_awid, m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_bid;
   logic [31:0] m_axi_awaddr;
   logic [7:0]  m_axi_awlen, m_axi_wstrb;
   logic [2:0]  m_axi_awsize, m_axi_awprot;
   logic [1:0]  m_axi_awburst, m_axi_bresp;
   logic        m_axi_awlock, m_axi_awvalid, m_axi_awready;
   logic [63:0] m_axi_wdata;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;

   always #5 clk = ~clk;

   fifo_to_axi4 dut (
      .clk(clk), .reset_n(reset_n), .WR_AXI_BYTE_ADDR_END(end_addr), .addr_clr(addr_clr),
      .fifo_rdreq(fifo_rdreq), .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
      .fifo_rd_cnt(fifo_rd_cnt), .fifo_rst_busy(fifo_rst_busy), .wr_resp_err(wr_resp_err),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   typedef struct {
      logic [23:0] end_a;
      int          clr_beat;
      bit          rnd;
      int          aw_dly;
      logic [1:0]  bresp;
      logic [3:0]  bid;
      logic [31:0] exp_addr;
      logic [31:0] exp_next;
      logic        exp_err;
   } vec_t;

   vec_t        vt[24];
   logic [63:0] fq[$];
   logic [63:0] exp_q[$];
   logic [63:0] word_ctr = 64'd0;
   logic [63:0] prev_wdata;
   logic        prev_wlast;
   int          n_vec = 0, n_bad = 0;
   int          beats, aw_cycles, aw_hs, clr_beat_cur, aw_dly_cur;
   logic [31:0] aw_addr;
   bit          b_done, pop_pend, prev_stall, clr_req, rnd_cur;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      fifo_empty  = (fq.size() == 0);
      fifo_rddata = fifo_empty ? 64'd0 : fq[0];
      fifo_rd_cnt = 8'((fq.size() > 255) ? 255 : fq.size());
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(word_ctr);
         exp_q.push_back(word_ctr);
         word_ctr = word_ctr + 64'd1;
      end
      refresh();
   endtask

   // Drive just after the rising edge, observe on the falling edge.
   task automatic tick();
      logic [63:0] tmp, e;
      @(posedge clk);
      #1;
      if (pop_pend) begin
         if (fq.size() > 0) tmp = fq.pop_front();
         pop_pend = 1'b0;
      end
      refresh();
      m_axi_wready  = rnd_cur ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_awready = (aw_cycles >= aw_dly_cur);
      addr_clr      = clr_req;
      clr_req       = 1'b0;
      @(negedge clk);
      chk("rdreq", 64'(fifo_rdreq), 64'(m_axi_wvalid && m_axi_wready));
      if (m_axi_awvalid) begin
         aw_cycles++;
         if (m_axi_awready) begin
            aw_addr = m_axi_awaddr;
            aw_hs++;
            chk("awlen", 64'(m_axi_awlen), 64'd31);
            chk("awsize", 64'(m_axi_awsize), 64'd3);
            chk("aw_misc", 64'({m_axi_awburst, m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot,
                                m_axi_awqos, m_axi_awregion, m_axi_wstrb}),
                64'({2'b01, 4'h0, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 8'hFF}));
         end
      end
      if (prev_stall) begin
         chk("w_hold_vld", 64'(m_axi_wvalid), 64'd1);
         chk("w_hold_dat", m_axi_wdata, prev_wdata);
         chk("w_hold_last", 64'(m_axi_wlast), 64'(prev_wlast));
      end
      prev_stall = m_axi_wvalid && !m_axi_wready;
      prev_wdata = m_axi_wdata;
      prev_wlast = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
         if (exp_q.size() == 0) chk("wdata_extra", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("wdata", m_axi_wdata, e);
         end
         chk("wlast", 64'(m_axi_wlast), 64'(beats == 31));
         beats++;
         pop_pend = 1'b1;
         if (beats == clr_beat_cur) clr_req = 1'b1;
      end
      if (m_axi_bvalid && m_axi_bready) b_done = 1'b1;
   endtask

   task automatic start_burst();
      beats = 0; aw_cycles = 0; aw_hs = 0; b_done = 1'b0;
   endtask

   task automatic finish_burst(input logic [31:0] ea, input logic [31:0] en, input logic ee, input int dly);
      for (int c = 0; c < 3000 && !b_done; c++) tick();
      chk("b_done", 64'(b_done), 64'd1);
      chk("awaddr", 64'(aw_addr), 64'(ea));
      chk("aw_count", 64'(aw_hs), 64'd1);
      chk("beats", 64'(beats), 64'd32);
      chk("aw_hold", 64'(aw_cycles), 64'(dly + 1));
      tick();
      chk("resp_err", 64'(wr_resp_err), 64'(ee));
      chk("next_addr", 64'(m_axi_awaddr), 64'(en));
      tick();
      chk("err_pulse", 64'(wr_resp_err), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         vt[i] = '{24'h1000, -1, 1'b0, 0, 2'b00, 4'h0, 32'(i * 256),
                   (i == 15) ? 32'h0 : 32'((i + 1) * 256), 1'b0};
      vt[3].rnd = 1'b1;  vt[3].aw_dly = 5;
      vt[16] = '{24'h1000, -1, 1'b0, 0, 2'b00, 4'h0, 32'h000, 32'h100, 1'b0};
      vt[17] = '{24'h1000, -1, 1'b0, 0, 2'b00, 4'h0, 32'h100, 32'h200, 1'b0};
      vt[18] = '{24'h1000, -1, 1'b0, 0, 2'b00, 4'h0, 32'h200, 32'h300, 1'b0};
      vt[19] = '{24'h1000, 10, 1'b0, 0, 2'b00, 4'h0, 32'h300, 32'h000, 1'b0};
      vt[20] = '{24'h1000, -1, 1'b0, 0, 2'b10, 4'h0, 32'h000, 32'h100, 1'b1};
      vt[21] = '{24'h1000, -1, 1'b0, 0, 2'b00, 4'h1, 32'h100, 32'h200, 1'b1};
      vt[22] = '{24'h0300, -1, 1'b0, 0, 2'b00, 4'h0, 32'h200, 32'h000, 1'b0};
      vt[23] = '{24'h1000, -1, 1'b1, 2, 2'b00, 4'h0, 32'h000, 32'h100, 1'b0};

      end_addr = 24'h1000; addr_clr = 1'b0; fifo_rst_busy = 1'b0;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
      m_axi_bresp = 2'b00; m_axi_bid = 4'h0;
      rnd_cur = 1'b0; aw_dly_cur = 0; clr_beat_cur = -1; clr_req = 1'b0;
      pop_pend = 1'b0; prev_stall = 1'b0; aw_addr = 32'h0;
      refresh();
      start_burst();
      #3;
      chk("rst_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, fifo_rdreq, wr_resp_err}), 64'd0);
      chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();

      for (int v = 0; v < 24; v++) begin
         end_addr = vt[v].end_a; rnd_cur = vt[v].rnd; aw_dly_cur = vt[v].aw_dly;
         m_axi_bresp = vt[v].bresp; m_axi_bid = vt[v].bid; clr_beat_cur = vt[v].clr_beat;
         start_burst();
         push(32);
         finish_burst(vt[v].exp_addr, vt[v].exp_next, vt[v].exp_err, vt[v].aw_dly);
      end

      // Start threshold: 31 words must not start a burst, the 32nd must.
      end_addr = 24'h1000; rnd_cur = 1'b0; aw_dly_cur = 0; clr_beat_cur = -1;
      m_axi_bresp = 2'b00; m_axi_bid = 4'h0;
      start_burst();
      push(31);
      for (int i = 0; i < 20; i++) tick();
      chk("no_aw_31", 64'(aw_cycles), 64'd0);
      push(1);
      tick(); tick();
      chk("aw_at_32", 64'(aw_cycles > 0), 64'd1);
      finish_burst(32'h100, 32'h200, 1'b0, 0);

      // FIFO in reset holds off requests; then reset the DUT mid-burst.
      start_burst();
      fifo_rst_busy = 1'b1;
      push(40);
      for (int i = 0; i < 20; i++) tick();
      chk("no_aw_busy", 64'(aw_cycles), 64'd0);
      fifo_rst_busy = 1'b0;
      for (int i = 0; i < 200 && beats < 5; i++) tick();
      chk("in_wdata", 64'(m_axi_wvalid), 64'd1);
      chk("pre_rst_addr", 64'(m_axi_awaddr), 64'h200);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, fifo_rdreq, wr_resp_err}), 64'd0);
      chk("mid_rst_awaddr", 64'(m_axi_awaddr), 64'd0);
      fq.delete(); exp_q.delete(); pop_pend = 1'b0; prev_stall = 1'b0;
      refresh();
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_idle", 64'({m_axi_awvalid, m_axi_awaddr}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
